// File: rtl/control_sequencer.sv
// Microcoded control sequencer: steps through variable-length instructions,
// drives the external microcode ROM address and gates its control word onto the datapath.
module control_sequencer #(
   parameter int                  INSTR_W    = 8,
   parameter int                  STEP_W     = 3,
   parameter int                  FLAG_W     = 2,
   parameter int                  CTRL_W     = 16,
   parameter int                  END_BIT    = 0,
   parameter int                  FETCH_STEP = 1,
   parameter logic [INSTR_W-1:0]  HLT_OPCODE = '1,
   parameter logic [CTRL_W-1:0]   CTRL_IDLE  = '0,
   parameter logic [CTRL_W-1:0]   WR_MASK    = '0,
   parameter int                  IMM_LSB    = 3,
   parameter int                  IMM_W      = 3
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic [FLAG_W-1:0]                  i_flags,
   input  logic [INSTR_W-1:0]                 i_instruction,
   input  logic                               i_stall,
   input  logic                               i_singleStep,
   input  logic                               i_stepReq,
   input  logic [CTRL_W-1:0]                  i_ucode,
   output logic [FLAG_W+INSTR_W+STEP_W-1:0]   o_ucodeAddr,
   output logic [CTRL_W-1:0]                  o_ctrl,
   output logic [2:0]                         o_aluMode,
   output logic [INSTR_W-1:0]                 o_immediate,
   output logic                               o_fetch,
   output logic [STEP_W-1:0]                  o_step,
   output logic                               o_paused,
   output logic                               o_halted
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      HALT  = 2'd2
   } seqState_e;

   localparam logic [STEP_W-1:0] MAX_STEP   = '1;
   localparam logic [STEP_W-1:0] FETCH_S    = STEP_W'(FETCH_STEP);
   localparam logic [STEP_W-1:0] HALT_STEP  = STEP_W'(FETCH_STEP + 1);

   seqState_e           state, stateNext;
   logic [STEP_W-1:0]   step, stepNext;
   logic [INSTR_W-1:0]  instr, instrNext;
   logic                isFetch;
   logic                instrEnd;
   logic [CTRL_W-1:0]   ctrlNext;
   logic                fetchNext;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= RUN;
         step  <= '0;
         instr <= '0;
      end else begin
         state <= stateNext;
         step  <= stepNext;
         instr <= instrNext;
      end
   end

   // The end bit only counts once the fetch step is behind us, so every
   // instruction is guaranteed to fetch; running off the top of the counter also ends it.
   always_comb begin
      isFetch  = (step == FETCH_S);
      instrEnd = (i_ucode[END_BIT] && (step > FETCH_S)) || (step == MAX_STEP);
   end

   always_comb begin
      stateNext = state;
      stepNext  = step;
      instrNext = instr;
      ctrlNext  = CTRL_IDLE;
      fetchNext = 1'b0;

      case (state)
         RUN: begin
            if (i_stall) begin
               ctrlNext = (i_ucode & ~WR_MASK) | (CTRL_IDLE & WR_MASK);
            end else begin
               ctrlNext = i_ucode;
               if (isFetch) begin
                  fetchNext = 1'b1;
                  instrNext = i_instruction;
                  if (i_instruction == HLT_OPCODE) begin
                     stateNext = HALT;
                     stepNext  = HALT_STEP;
                  end else begin
                     stepNext  = step + 1'b1;
                  end
               end else if (instrEnd) begin
                  stepNext = '0;
                  if (i_singleStep) begin
                     stateNext = PAUSE;
                  end
               end else begin
                  stepNext = step + 1'b1;
               end
            end
         end

         PAUSE: begin
            stepNext = '0;
            if (i_stepReq || !i_singleStep) begin
               stateNext = RUN;
            end
         end

         HALT: begin
            stateNext = HALT;
         end

         default: begin
            stateNext = RUN;
            stepNext  = '0;
         end
      endcase

      // Reset takes effect at the next edge, but the strobes go quiet immediately.
      if (i_reset) begin
         ctrlNext  = CTRL_IDLE;
         fetchNext = 1'b0;
      end
   end

   always_comb begin
      o_immediate              = '0;
      o_immediate[IMM_W-1:0]   = instr[IMM_LSB +: IMM_W];
   end

   assign o_ucodeAddr = {i_flags, instr, step};
   assign o_ctrl      = ctrlNext;
   assign o_fetch     = fetchNext;
   assign o_aluMode   = instr[2:0];
   assign o_step      = step;
   assign o_paused    = (state == PAUSE);
   assign o_halted    = (state == HALT);

endmodule
